// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - instruction, regfile and ALU signal bundle of regfile_sequencer
// master is the sequencer side; slave is the issue/regfile/ALU side.
interface regfile_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int OP_WIDTH   = 4
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [ADDR_WIDTH-1:0] instr_rs1;
  logic [ADDR_WIDTH-1:0] instr_rs2;
  logic [ADDR_WIDTH-1:0] instr_rd;
  logic [OP_WIDTH-1:0]   instr_op;
  logic                  instr_use_imm;
  logic [DATA_WIDTH-1:0] instr_imm;
  logic [ADDR_WIDTH-1:0] read_address1;
  logic [ADDR_WIDTH-1:0] read_address2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [OP_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    input  instr_valid, instr_rs1, instr_rs2, instr_rd, instr_op, instr_use_imm, instr_imm,
    input  read_data1, read_data2, alu_result,
    output instr_ready, read_address1, read_address2, alu_a, alu_b, alu_op,
    output write_enable, write_address, write_data, done, result
  );

  modport slave (
    output instr_valid, instr_rs1, instr_rs2, instr_rd, instr_op, instr_use_imm, instr_imm,
    output read_data1, read_data2, alu_result,
    input  instr_ready, read_address1, read_address2, alu_a, alu_b, alu_op,
    input  write_enable, write_address, write_data, done, result
  );
endinterface

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - four-cycle fetch/exec/writeback sequencer for the regfile and ALU
// One instruction per handshake; the write strobe is combinational so an async reset kills it at once.
module regfile_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int OP_WIDTH   = 4
) (
  input logic                clk,
  input logic                reset,
  regfile_sequencer_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WRITEBACK
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic                  use_imm_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  instr_ready;
  logic                  write_enable;
  logic                  done;
  logic                  accept;

  assign accept = instr_ready & bus.instr_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    write_enable = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        // r0 is architecturally constant, so it is never strobed
        write_enable = (rd_q != '0);
        done         = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      op_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      operand_a <= '0;
      operand_b <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        rs1_q     <= bus.instr_rs1;
        rs2_q     <= bus.instr_rs2;
        rd_q      <= bus.instr_rd;
        op_q      <= bus.instr_op;
        use_imm_q <= bus.instr_use_imm;
        imm_q     <= bus.instr_imm;
      end
      if (state_q == S_FETCH) begin
        operand_a <= bus.read_data1;
        operand_b <= use_imm_q ? imm_q : bus.read_data2;
      end
      if (state_q == S_EXEC) begin
        result_q <= bus.alu_result;
      end
    end
  end

  assign bus.instr_ready   = instr_ready;
  assign bus.read_address1 = rs1_q;
  assign bus.read_address2 = rs2_q;
  assign bus.alu_a         = operand_a;
  assign bus.alu_b         = operand_b;
  assign bus.alu_op        = op_q;
  assign bus.write_enable  = write_enable;
  assign bus.write_address = rd_q;
  assign bus.write_data    = result_q;
  assign bus.done          = done;
  assign bus.result        = result_q;
endmodule
